// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - byte-wide RAM/IO port arbiter between icache and dcache
//
// Purpose: grants the single 8-bit RAM/IO port to one requester per cycle.
// The dcache has fixed priority over the icache. One registered acknowledge
// follows every issued byte, so both caches can stream back-to-back.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   ic_get_en/ic_addr icache byte read request
//   ic_out_en         ack for the icache byte issued last cycle
//   ic_content        read byte to icache (valid with ic_out_en)
//   dc_get_en, dc_write_mode, dc_addr, dc_data
//                     dcache byte read/write request
//   dc_out_en         ack for the dcache byte issued last cycle
//   dc_content        read byte to dcache (valid with dc_out_en)
//   io_buffer_full    IO write buffer cannot accept a write
//   ram_a/ram_wr/ram_dout/ram_din
//                     RAM/IO port; ram_din is valid the cycle after ram_a

module mem_arbiter #(
  parameter int ADDR_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ic_get_en,
  input  logic [ADDR_W-1:0] ic_addr,
  output logic              ic_out_en,
  output logic [7:0]        ic_content,
  input  logic              dc_get_en,
  input  logic              dc_write_mode,
  input  logic [ADDR_W-1:0] dc_addr,
  input  logic [7:0]        dc_data,
  output logic              dc_out_en,
  output logic [7:0]        dc_content,
  input  logic              io_buffer_full,
  output logic [ADDR_W-1:0] ram_a,
  output logic              ram_wr,
  output logic [7:0]        ram_dout,
  input  logic [7:0]        ram_din
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IC   = 2'd1,
    OWN_DC   = 2'd2
  } owner_t;

  owner_t pending;
  owner_t pending_next;

  logic io_sel;
  logic io_stall;
  logic issue_dc;
  logic issue_ic;

  // The issue decision depends only on the request inputs and reset, never on
  // the acks, because requesters move their address off *_out_en.
  always_comb begin
    io_sel   = (dc_addr[ADDR_W-1 -: 2] == 2'b11);
    io_stall = dc_get_en & dc_write_mode & io_sel & io_buffer_full;
    issue_dc = rst & dc_get_en & ~io_stall;
    // Any dcache request blocks the icache, including a stalled IO write,
    // so the port stays reserved until the IO buffer drains.
    issue_ic = rst & ~dc_get_en & ic_get_en;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pending <= OWN_NONE;
    end else begin
      pending <= pending_next;
    end
  end

  always_comb begin
    pending_next = OWN_NONE;
    ram_a        = '0;
    ram_wr       = 1'b0;
    ram_dout     = 8'h00;
    if (issue_dc) begin
      pending_next = OWN_DC;
      ram_a        = dc_addr;
      ram_wr       = dc_write_mode;
      ram_dout     = dc_write_mode ? dc_data : 8'h00;
    end else if (issue_ic) begin
      pending_next = OWN_IC;
      ram_a        = ic_addr;
    end
  end

  // Acks decode the registered owner; read data passes straight from ram_din.
  always_comb begin
    ic_out_en  = (pending == OWN_IC);
    dc_out_en  = (pending == OWN_DC);
    ic_content = (pending == OWN_IC) ? ram_din : 8'h00;
    dc_content = (pending == OWN_DC) ? ram_din : 8'h00;
  end

endmodule
